// File: rtl/tl_pkg.sv
// Shared definitions for the intersection lamp-bus sequence monitor:
// lamp bit positions, phase encoding, fault codes and a priority helper.
package tl_pkg;

  localparam int LAMP_G   = 2;
  localparam int LAMP_Y   = 1;
  localparam int LAMP_R   = 0;
  localparam int NUM_APPR = 4;
  localparam int DUR_W    = 8;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    ALLRED = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } phase_t;

  localparam logic [2:0] FC_NONE        = 3'd0;
  localparam logic [2:0] FC_BAD_ENC     = 3'd1;
  localparam logic [2:0] FC_CONFLICT    = 3'd2;
  localparam logic [2:0] FC_BAD_TRANS   = 3'd3;
  localparam logic [2:0] FC_GREEN_TIME  = 3'd4;
  localparam logic [2:0] FC_YELLOW_TIME = 3'd5;
  localparam logic [2:0] FC_ORDER       = 3'd6;
  localparam logic [2:0] FC_PED         = 3'd7;

  // Lowest-index approach flagged in an offender mask.
  function automatic logic [1:0] first_set(input logic [NUM_APPR-1:0] m);
    first_set = 2'd0;
    for (int i = NUM_APPR - 1; i >= 0; i--) begin
      if (m[i]) first_set = 2'(i);
    end
  endfunction

endpackage

// File: rtl/tl_lamp_decode.sv
// Per-approach lamp decoder: one-hot {G,Y,R} to flags; anything not
// exactly one-hot (including all-dark) raises bad_enc.
module tl_lamp_decode
  import tl_pkg::*;
(
  input  logic [2:0] lamp,
  output logic       is_r,
  output logic       is_y,
  output logic       is_g,
  output logic       bad_enc
);

  assign is_r    =  lamp[LAMP_R] & ~lamp[LAMP_Y] & ~lamp[LAMP_G];
  assign is_y    = ~lamp[LAMP_R] &  lamp[LAMP_Y] & ~lamp[LAMP_G];
  assign is_g    = ~lamp[LAMP_R] & ~lamp[LAMP_Y] &  lamp[LAMP_G];
  assign bad_enc = ~(is_r | is_y | is_g);

endmodule

// File: rtl/tl_sequence_monitor.sv
// Receive-side safety/timing checker for the four-way lamp and walk bus.
// Define FAULT_RECOVER_EN to let the fault clear after a sustained all-red.
module tl_sequence_monitor
  import tl_pkg::*;
#(
  parameter int unsigned GREEN_TICKS  = 4,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned ALLRED_MIN   = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [2:0]       tl_1,
  input  logic [2:0]       tl_2,
  input  logic [2:0]       tl_3,
  input  logic [2:0]       tl_4,
  input  logic             ped_1,
  input  logic             ped_2,
  input  logic             ped_3,
  input  logic             ped_4,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [1:0]       fault_appr,
  output logic [1:0]       active_appr,
  output logic [1:0]       phase,
  output logic             cycle_pulse,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [DUR_W-1:0] G_LEN  = DUR_W'(GREEN_TICKS);
  localparam logic [DUR_W-1:0] Y_LEN  = DUR_W'(YELLOW_TICKS);
  localparam logic [DUR_W-1:0] AR_MIN = DUR_W'(ALLRED_MIN);

  logic [NUM_APPR-1:0][2:0] lamp_v;
  logic [NUM_APPR-1:0]      is_r, is_y, is_g, bad_enc, ped_pair;

  phase_t                   phase_q, phase_d;
  logic [1:0]               act_q, act_d, nxt;
  logic [DUR_W-1:0]         cnt_q, cnt_d;
  logic [NUM_APPR-1:0]      hist_r_q, hist_y_q, hist_g_q;
  logic [NUM_APPR-1:0]      hist_r_d, hist_y_d, hist_g_d;
  logic                     fault_q, fault_d;
  logic [2:0]               code_q, code_d;
  logic [1:0]               fappr_q, fappr_d;
  logic                     pulse_q, pulse_d;
  logic [CNT_W-1:0]         cyc_q, cyc_d;
`ifdef FAULT_RECOVER_EN
  localparam logic [DUR_W-1:0] REC_LEN = DUR_W'(YELLOW_TICKS + ALLRED_MIN);
  logic [DUR_W-1:0]         rec_q, rec_d;
`endif

  logic                     checking;
  logic [NUM_APPR-1:0]      lit, act_oh, onset;
  logic [NUM_APPR-1:0]      m_enc, m_conf, m_trans, m_order, m_green, m_yel, m_ped;
  logic [NUM_APPR-1:0]      sel_mask;
  logic [2:0]               sel_code;
  logic [1:0]               sel_appr;

  assign lamp_v   = {tl_4, tl_3, tl_2, tl_1};
  // Walk ped_((k mod 4)+1) belongs to approach k, so rotate by one.
  assign ped_pair = {ped_1, ped_4, ped_3, ped_2};

  for (genvar k = 0; k < NUM_APPR; k++) begin : g_dec
    tl_lamp_decode u_dec (
      .lamp    (lamp_v[k]),
      .is_r    (is_r[k]),
      .is_y    (is_y[k]),
      .is_g    (is_g[k]),
      .bad_enc (bad_enc[k])
    );
  end

  always_comb begin
    checking = (phase_q != INIT);
    lit      = is_g | is_y;
    act_oh   = 4'd1 << act_q;
    nxt      = act_q + 2'd1;
    onset    = checking ? (hist_r_q & is_g) : '0;

    m_enc = '0;
    for (int k = 0; k < NUM_APPR; k++) begin
      m_enc[k] = bad_enc[k] & ~((phase_q == INIT) & (lamp_v[k] == 3'b000));
    end

    m_conf  = ((lit & (lit - 4'd1)) != '0) ? lit : '0;
    m_trans = checking ? ((hist_g_q & is_r) | (hist_y_q & is_g) | (hist_r_q & is_y)) : '0;
    m_order = onset & ~(4'd1 << nxt);

    // A new green also needs enough all-red behind it; none at all if the
    // previous approach is only now leaving yellow.
    m_green = '0;
    if ((phase_q != ALLRED) || (cnt_q < AR_MIN)) m_green = onset;
    if ((phase_q == GREEN) &&
        ((is_y[act_q] && (cnt_q != G_LEN)) || (is_g[act_q] && (cnt_q >= G_LEN))))
      m_green = m_green | act_oh;

    m_yel = '0;
    if ((phase_q == YELLOW) &&
        ((is_r[act_q] && (cnt_q != Y_LEN)) || (is_y[act_q] && (cnt_q >= Y_LEN))))
      m_yel = act_oh;

    m_ped = checking ? (ped_pair ^ lit) : '0;
  end

  always_comb begin
    sel_code = FC_NONE;
    sel_mask = '0;
    if (m_enc != '0) begin
      sel_code = FC_BAD_ENC;     sel_mask = m_enc;
    end else if (m_conf != '0) begin
      sel_code = FC_CONFLICT;    sel_mask = m_conf;
    end else if (m_trans != '0) begin
      sel_code = FC_BAD_TRANS;   sel_mask = m_trans;
    end else if (m_order != '0) begin
      sel_code = FC_ORDER;       sel_mask = m_order;
    end else if (m_green != '0) begin
      sel_code = FC_GREEN_TIME;  sel_mask = m_green;
    end else if (m_yel != '0) begin
      sel_code = FC_YELLOW_TIME; sel_mask = m_yel;
    end else if (m_ped != '0) begin
      sel_code = FC_PED;         sel_mask = m_ped;
    end
    sel_appr = first_set(sel_mask);
  end

  // Phase tracking; once faulted everything freezes until reset/recovery.
  always_comb begin
    phase_d  = phase_q;
    act_d    = act_q;
    cnt_d    = cnt_q;
    hist_r_d = hist_r_q;
    hist_y_d = hist_y_q;
    hist_g_d = hist_g_q;
    fault_d  = fault_q;
    code_d   = code_q;
    fappr_d  = fappr_q;
    pulse_d  = 1'b0;
    cyc_d    = cyc_q;
`ifdef FAULT_RECOVER_EN
    rec_d    = rec_q;
`endif

    if (tick) begin
      if (fault_q) begin
`ifdef FAULT_RECOVER_EN
        if (is_r == '1) begin
          if (rec_q >= REC_LEN - DUR_W'(1)) begin
            fault_d  = 1'b0;
            phase_d  = INIT;
            act_d    = 2'd3;
            cnt_d    = '0;
            hist_r_d = '1;
            hist_y_d = '0;
            hist_g_d = '0;
            rec_d    = '0;
          end else begin
            rec_d = rec_q + DUR_W'(1);
          end
        end else begin
          rec_d = '0;
        end
`endif
      end else if (sel_code != FC_NONE) begin
        fault_d = 1'b1;
        code_d  = sel_code;
        fappr_d = sel_appr;
      end else begin
        hist_r_d = is_r;
        hist_y_d = is_y;
        hist_g_d = is_g;
        case (phase_q)
          INIT: begin
            if (is_r == '1) begin
              phase_d = ALLRED;
              act_d   = 2'd3;
              cnt_d   = DUR_W'(1);
            end
          end
          ALLRED: begin
            if (onset != '0) begin
              phase_d = GREEN;
              act_d   = nxt;
              cnt_d   = DUR_W'(1);
            end else if (cnt_q != '1) begin
              cnt_d = cnt_q + DUR_W'(1);
            end
          end
          GREEN: begin
            if (is_y[act_q]) begin
              phase_d = YELLOW;
              cnt_d   = DUR_W'(1);
            end else begin
              cnt_d = cnt_q + DUR_W'(1);
            end
          end
          YELLOW: begin
            if (is_r[act_q]) begin
              phase_d = ALLRED;
              cnt_d   = DUR_W'(1);
              if (act_q == 2'd3) begin
                pulse_d = 1'b1;
                if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
              end
            end else begin
              cnt_d = cnt_q + DUR_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= INIT;
      act_q    <= 2'd3;
      cnt_q    <= '0;
      hist_r_q <= '1;
      hist_y_q <= '0;
      hist_g_q <= '0;
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
      fappr_q  <= 2'd0;
      pulse_q  <= 1'b0;
      cyc_q    <= '0;
`ifdef FAULT_RECOVER_EN
      rec_q    <= '0;
`endif
    end else begin
      phase_q  <= phase_d;
      act_q    <= act_d;
      cnt_q    <= cnt_d;
      hist_r_q <= hist_r_d;
      hist_y_q <= hist_y_d;
      hist_g_q <= hist_g_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      fappr_q  <= fappr_d;
      pulse_q  <= pulse_d;
      cyc_q    <= cyc_d;
`ifdef FAULT_RECOVER_EN
      rec_q    <= rec_d;
`endif
    end
  end

  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign fault_appr  = fappr_q;
  assign active_appr = act_q;
  assign phase       = phase_q;
  assign cycle_pulse = pulse_q;
  assign cycle_cnt   = cyc_q;

endmodule

// File: tb/tb_tl_sequence_monitor.sv
// Directed bench for tl_sequence_monitor: a nominal two-rotation table plus
// hand-written fault, reset and recovery (FAULT_RECOVER_EN) sequences.
module tb_tl_sequence_monitor;

  localparam logic [2:0] LR = 3'b001;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b100;

  typedef logic [3:0][2:0] lamps_t;

  typedef struct {
    lamps_t      lamps;
    logic [3:0]  ped;
    logic        fault;
    logic [2:0]  code;
    logic [1:0]  fappr;
    logic [1:0]  act;
    logic [1:0]  phase;
    logic        pulse;
    logic [15:0] cyc;
  } vec_t;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        tick = 1'b0;
  logic [2:0]  tl_1 = LR, tl_2 = LR, tl_3 = LR, tl_4 = LR;
  logic [3:0]  ped_v = 4'b0000;
  logic        fault, cycle_pulse;
  logic [2:0]  fault_code;
  logic [1:0]  fault_appr, active_appr, phase;
  logic [15:0] cycle_cnt;

  int errors = 0;
  int checks = 0;
  vec_t nom [57];

  always #5 clk = ~clk;

  tl_sequence_monitor #(
    .GREEN_TICKS (4),
    .YELLOW_TICKS(2),
    .ALLRED_MIN  (1),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .tl_1       (tl_1),
    .tl_2       (tl_2),
    .tl_3       (tl_3),
    .tl_4       (tl_4),
    .ped_1      (ped_v[0]),
    .ped_2      (ped_v[1]),
    .ped_3      (ped_v[2]),
    .ped_4      (ped_v[3]),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_appr (fault_appr),
    .active_appr(active_appr),
    .phase      (phase),
    .cycle_pulse(cycle_pulse),
    .cycle_cnt  (cycle_cnt)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One idle clock with tick low, then one tick; returns #1 after the tick edge.
  task automatic applyStimulus(input lamps_t l, input logic [3:0] p);
    @(posedge clk);
    #1;
    tl_1  = l[0];
    tl_2  = l[1];
    tl_3  = l[2];
    tl_4  = l[3];
    ped_v = p;
    tick  = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkVal({tag, ".fault"},       32'(fault),       32'(v.fault));
    checkVal({tag, ".fault_code"},  32'(fault_code),  32'(v.code));
    checkVal({tag, ".fault_appr"},  32'(fault_appr),  32'(v.fappr));
    checkVal({tag, ".active_appr"}, 32'(active_appr), 32'(v.act));
    checkVal({tag, ".phase"},       32'(phase),       32'(v.phase));
    checkVal({tag, ".cycle_pulse"}, 32'(cycle_pulse), 32'(v.pulse));
    checkVal({tag, ".cycle_cnt"},   32'(cycle_cnt),   32'(v.cyc));
  endtask

  task automatic checkFault(input string tag, input logic f, input logic [2:0] c,
                            input logic [1:0] a, input logic [1:0] ph);
    checkVal({tag, ".fault"},      32'(fault),      32'(f));
    checkVal({tag, ".fault_code"}, 32'(fault_code), 32'(c));
    checkVal({tag, ".fault_appr"}, 32'(fault_appr), 32'(a));
    checkVal({tag, ".phase"},      32'(phase),      32'(ph));
  endtask

  task automatic checkReset(input string tag);
    vec_t v;
    v.lamps = {4{LR}}; v.ped = 4'b0000;
    v.fault = 1'b0; v.code = 3'd0; v.fappr = 2'd0; v.act = 2'd3;
    v.phase = 2'd0; v.pulse = 1'b0; v.cyc = 16'd0;
    checkOutput(v, tag);
  endtask

  task automatic doRst();
    tl_1 = LR; tl_2 = LR; tl_3 = LR; tl_4 = LR; ped_v = 4'b0000; tick = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic allRed();
    applyStimulus({4{LR}}, 4'b0000);
  endtask

  // Approach a (0..3): g green ticks, y yellow ticks, r all-red ticks.
  task automatic runPhase(input int a, input int g, input int y, input int r);
    lamps_t l;
    logic [3:0] p;
    for (int i = 0; i < g + y + r; i++) begin
      l = {4{LR}};
      p = 4'b0000;
      if (i < g) l[a] = LG;
      else if (i < g + y) l[a] = LY;
      if (i < g + y) p[(a + 1) % 4] = 1'b1;
      applyStimulus(l, p);
    end
  endtask

  function automatic vec_t mk(input lamps_t l, input logic [3:0] p, input logic [1:0] act,
                              input logic [1:0] ph, input logic pulse, input logic [15:0] cyc);
    vec_t v;
    v.lamps = l; v.ped = p;
    v.fault = 1'b0; v.code = 3'd0; v.fappr = 2'd0;
    v.act = act; v.phase = ph; v.pulse = pulse; v.cyc = cyc;
    return v;
  endfunction

  initial begin
    lamps_t     l;
    logic [3:0] p;
    logic [1:0] ph;
    logic       last;
    int         n;

    // Nominal stream: one all-red tick, then G4/Y2/R1 per approach, two rotations.
    nom[0] = mk({4{LR}}, 4'b0000, 2'd3, 2'd1, 1'b0, 16'd0);
    n = 1;
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 4; a++) begin
        for (int s = 0; s < 7; s++) begin
          l = {4{LR}};
          p = 4'b0000;
          if (s < 4) l[a] = LG;
          else if (s < 6) l[a] = LY;
          if (s < 6) p[(a + 1) % 4] = 1'b1;
          ph   = (s < 4) ? 2'd2 : ((s < 6) ? 2'd3 : 2'd1);
          last = (s == 6) && (a == 3);
          nom[n] = mk(l, p, 2'(a), ph, last, 16'(r + (last ? 1 : 0)));
          n++;
        end
      end
    end

    $display("[TB] power-on reset");
    #2 rst = 1'b1;
    #2 checkReset("por");
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] nominal two-rotation stream");
    for (int i = 0; i < 57; i++) begin
      applyStimulus(nom[i].lamps, nom[i].ped);
      checkOutput(nom[i], $sformatf("nom[%0d]", i));
      if (nom[i].pulse) begin
        @(posedge clk);
        #1;
        checkVal($sformatf("nom[%0d].hold_pulse", i), 32'(cycle_pulse), 32'd0);
        checkVal($sformatf("nom[%0d].hold_cnt", i),   32'(cycle_cnt),   32'(nom[i].cyc));
      end
    end

    $display("[TB] conflict: approaches 2 and 3 green together");
    doRst();
    allRed();
    runPhase(0, 4, 2, 1);
    l = {4{LR}}; l[1] = LG; l[2] = LG;
    applyStimulus(l, 4'b1100);
    checkFault("conflict", 1'b1, 3'd2, 2'd1, 2'd1);
    allRed();
    allRed();
    checkFault("conflict_frozen", 1'b1, 3'd2, 2'd1, 2'd1);
    checkVal("conflict_frozen.active_appr", 32'(active_appr), 32'd0);

    $display("[TB] short green");
    doRst();
    allRed();
    runPhase(0, 3, 1, 0);
    checkFault("short_green", 1'b1, 3'd4, 2'd0, 2'd2);

    $display("[TB] long yellow");
    doRst();
    allRed();
    runPhase(0, 4, 3, 0);
    checkFault("long_yellow", 1'b1, 3'd5, 2'd0, 2'd3);

    $display("[TB] out-of-order green");
    doRst();
    allRed();
    runPhase(0, 4, 2, 1);
    l = {4{LR}}; l[2] = LG;
    applyStimulus(l, 4'b1000);
    checkFault("order", 1'b1, 3'd6, 2'd2, 2'd1);

    $display("[TB] green straight to red");
    doRst();
    allRed();
    runPhase(0, 4, 0, 1);
    checkFault("g_to_r", 1'b1, 3'd3, 2'd0, 2'd2);

    $display("[TB] bad lamp encoding");
    doRst();
    allRed();
    l = {4{LR}}; l[1] = 3'b110;
    applyStimulus(l, 4'b0000);
    checkFault("bad_enc", 1'b1, 3'd1, 2'd1, 2'd1);

    $display("[TB] walk missing during green");
    doRst();
    allRed();
    l = {4{LR}}; l[0] = LG;
    applyStimulus(l, 4'b0000);
    checkFault("ped", 1'b1, 3'd7, 2'd0, 2'd1);

    $display("[TB] reset mid-green");
    doRst();
    allRed();
    runPhase(0, 2, 0, 0);
    checkVal("mid_green.phase", 32'(phase), 32'd2);
    #3 rst = 1'b1;
    #1 checkReset("mid_green_rst");
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] fault after a full rotation, then sustained all-red");
    doRst();
    allRed();
    for (int a = 0; a < 4; a++) runPhase(a, 4, 2, 1);
    checkVal("rot.cycle_cnt", 32'(cycle_cnt), 32'd1);
    l = {4{LR}}; l[0] = LG;
    applyStimulus(l, 4'b0000);
    checkFault("rot_ped", 1'b1, 3'd7, 2'd0, 2'd1);
    allRed();
    allRed();
    allRed();
`ifdef FAULT_RECOVER_EN
    checkFault("recover", 1'b0, 3'd7, 2'd0, 2'd0);
    checkVal("recover.cycle_cnt", 32'(cycle_cnt), 32'd1);
    allRed();
    checkVal("recover_allred.phase", 32'(phase), 32'd1);
    l = {4{LR}}; l[0] = LG;
    applyStimulus(l, 4'b0010);
    checkFault("recover_green", 1'b0, 3'd7, 2'd0, 2'd2);
    checkVal("recover_green.active_appr", 32'(active_appr), 32'd0);
`else
    checkFault("sticky", 1'b1, 3'd7, 2'd0, 2'd1);
    checkVal("sticky.cycle_cnt", 32'(cycle_cnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_sequence_monitor.md
Name: tl_sequence_monitor

Overview:
- Receive-side checker for the four-way intersection lamp/pedestrian bus: consumes TL_1..TL_4 (bit2=green, bit1=yellow, bit0=red) and PED_1..PED_4 exactly as the controller drives them.
- Decodes which approach holds the right-of-way and verifies safety and timing: single green, R→G→Y→R order, 1→2→3→4→1 rotation, phase durations, walk pairing.
- Reports a registered fault plus cycle statistics; sits beside the controller on the FPGA and drives the fault LED / safe-shutdown logic.

Parameters:
- GREEN_TICKS, 4, required green length in ticks.
- YELLOW_TICKS, 2, required yellow length in ticks.
- ALLRED_MIN, 1, minimum all-red ticks between phases.
- CNT_W, 16, width of cycle_cnt.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-clk strobe, one per controller second; inputs sampled only when tick=1
- tl_1..tl_4  in  3 each  lamp state {G,Y,R} of approaches 1..4
- ped_1..ped_4  in  1 each  walk signals; ped_((k mod 4)+1) is paired with approach k
- fault  out  1  fault detected
- fault_code  out  3  first fault cause (encoding below)
- fault_appr  out  2  approach index (0..3 = approach 1..4) at fault
- active_appr  out  2  approach currently green/yellow, or last one
- phase  out  2  0=INIT, 1=ALLRED, 2=GREEN, 3=YELLOW
- cycle_pulse  out  1  one-clk pulse when approach 4 yellow→red completes a rotation
- cycle_cnt  out  CNT_W  completed rotations, saturating

Behaviour:
- Reset (async, rst=1): fault=0, fault_code=0, fault_appr=0, active_appr=3, phase=INIT, cycle_pulse=0, cycle_cnt=0, duration counter=0, all history registers=red.
- All outputs registered; a sample taken on a tick clock edge is reflected on outputs one clk later. With tick=0 the state holds and cycle_pulse=0.
- Lamp decode per approach: exactly one bit set → R/Y/G. Value 000 is legal only in INIT. Any other value is fault code 1.
- INIT: waits for a tick with all four red; then moves to ALLRED, with expected next approach = 1 (active_appr=3 so that +1 wraps to 0).
- ALLRED: counts ticks. When one approach turns green:
  - it must equal (active_appr+1) mod 4, else code 6;
  - the all-red count must be ≥ALLRED_MIN, else code 4;
  - on pass → GREEN, counter=1.
- GREEN: counter increments each tick while the approach stays green.
  - Green→yellow requires counter==GREEN_TICKS, else code 4; on pass → YELLOW, counter=1.
  - Counter exceeding GREEN_TICKS is code 4.
- YELLOW: yellow→red requires counter==YELLOW_TICKS; a violation or overrun is code 5. On pass → ALLRED, counter=1.
  - If active_appr==3, cycle_pulse fires and cycle_cnt increments, saturating at all-ones.
- Transitions G→R, Y→G and R→Y on any approach are code 3.
- More than one approach non-red in the same sample is code 2.
- Walk pairing: the walk paired with approach k must be 1 exactly while k is G or Y; a mismatch is code 7. The walk drops on the same tick the lamp goes red, so there is no skew allowance.
- Priority when several checks fail in one sample: 1 > 2 > 3 > 6 > 4 > 5 > 7. fault_appr is the lowest-index offending approach.
- On fault: fault=1, code and approach are latched, phase freezes, and counters stop.
- Reset mid-operation returns to INIT immediately regardless of state.

Optional Feature:
- FAULT_RECOVER_EN defined: fault is not sticky. After YELLOW_TICKS+ALLRED_MIN consecutive all-red samples in the fault state, fault clears, fault_code/fault_appr are held for inspection, and the monitor re-enters INIT. cycle_cnt is preserved.
- FAULT_RECOVER_EN undefined: fault and its latched fields persist until rst.

Decomposition:
- Shared package tl_pkg holds:
  - lamp bit positions (G=2, Y=1, R=0);
  - phase enum {INIT, ALLRED, GREEN, YELLOW};
  - fault code constants: 1 BAD_ENC, 2 CONFLICT, 3 BAD_TRANS, 4 GREEN_TIME, 5 YELLOW_TIME, 6 ORDER, 7 PED;
  - approach count 4.
- One sub-module, tl_lamp_decode: combinational, per approach; takes 3 bits and returns {is_r, is_y, is_g, bad_enc}. Instantiated four times.

Test Plan:
- Nominal stream (all red 1 tick, each approach G4 Y2 R, rotation 1→4, two rotations) → fault stays 0, cycle_pulse twice, cycle_cnt=2, phase/active_appr track each tick.
- Approach 2 green and approach 3 green in the same sample → fault=1, code=2, fault_appr=1, outputs frozen.
- Approach 1 green only 3 ticks then yellow → code 4, fault_appr=0. Separately, yellow lasting 3 ticks → code 5.
- Approach 3 green after approach 1 completes → code 6, fault_appr=2. A separate run with G→R directly → code 3.
- tl_2=3'b110 during ALLRED → code 1. ped_2 low while approach 1 is green → code 7.
- Assert rst mid-GREEN → all outputs at reset values the same cycle. With FAULT_RECOVER_EN, fault then 3 all-red ticks → fault=0, phase=INIT, cycle_cnt unchanged.
